// File: rtl/load_unit_if.sv
// Load unit request/response and data-bus read signals.
// slave: the load unit; master: MEM stage plus data bus.
interface load_unit_if;
    logic        start;
    logic [31:0] addr;
    logic [2:0]  ctrl;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        bus_err;
    logic        busy;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic [1:0]  exc;

    modport slave (
        input  start, addr, ctrl,
        input  bus_rdata, bus_ack, bus_err,
        output bus_req, bus_addr,
        output busy, rd_valid, rd_data, exc
    );

    modport master (
        output start, addr, ctrl,
        output bus_rdata, bus_ack, bus_err,
        input  bus_req, bus_addr,
        input  busy, rd_valid, rd_data, exc
    );
endinterface

// File: rtl/load_unit.sv
// MEM-stage load unit: one word read per load, byte/half extraction,
// misalignment, bus-error and timeout exceptions.
module load_unit #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input logic        clk,
    input logic        reset,
    load_unit_if.slave lif
);
    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      baddr_q, baddr_d;
    logic [1:0]       off_q, off_d;
    logic [2:0]       ctrl_q, ctrl_d;
    logic [31:0]      data_q, data_d;
    logic [1:0]       exc_q, exc_d;

    logic        ld_type;
    logic        misal;
    logic        to_hit;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] ext_v;

    assign ld_type = (lif.ctrl != 3'd0) && (lif.ctrl <= 3'd5);
    assign misal   = ((lif.ctrl == 3'd1) && (lif.addr[1:0] != 2'd0))
                   || (((lif.ctrl == 3'd2) || (lif.ctrl == 3'd3))
                       && lif.addr[0]);
    // TIMEOUT of 0 disables the watchdog entirely
    assign to_hit  = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        byte_v = 8'd0;
        half_v = 16'd0;
        ext_v  = 32'd0;
        unique case (off_q)
            2'd0: byte_v = lif.bus_rdata[7:0];
            2'd1: byte_v = lif.bus_rdata[15:8];
            2'd2: byte_v = lif.bus_rdata[23:16];
            2'd3: byte_v = lif.bus_rdata[31:24];
            default: byte_v = 8'd0;
        endcase
        half_v = off_q[1] ? lif.bus_rdata[31:16] : lif.bus_rdata[15:0];
        unique case (ctrl_q)
            3'd1: ext_v = lif.bus_rdata;
            3'd2: ext_v = {16'd0, half_v};
            3'd3: ext_v = {{16{half_v[15]}}, half_v};
            3'd4: ext_v = {24'd0, byte_v};
            3'd5: ext_v = {{24{byte_v[7]}}, byte_v};
            default: ext_v = 32'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        baddr_d = baddr_q;
        off_d   = off_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        exc_d   = exc_q;
        unique case (state_q)
            IDLE: begin
                if (lif.start && ld_type) begin
                    if (misal) begin
                        exc_d   = 2'd1;
                        data_d  = 32'd0;
                        state_d = DONE;
                    end else begin
                        baddr_d = {lif.addr[31:2], 2'b00};
                        off_d   = lif.addr[1:0];
                        ctrl_d  = lif.ctrl;
                        cnt_d   = '0;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // error beats ack, ack beats timeout
                if (lif.bus_err) begin
                    exc_d   = 2'd2;
                    data_d  = 32'd0;
                    state_d = DONE;
                end else if (lif.bus_ack) begin
                    exc_d   = 2'd0;
                    data_d  = ext_v;
                    state_d = DONE;
                end else if (to_hit) begin
                    exc_d   = 2'd3;
                    data_d  = 32'd0;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            baddr_q <= 32'd0;
            off_q   <= 2'd0;
            ctrl_q  <= 3'd0;
            data_q  <= 32'd0;
            exc_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            baddr_q <= baddr_d;
            off_q   <= off_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
            exc_q   <= exc_d;
        end
    end

    assign lif.bus_req  = (state_q == WAIT);
    assign lif.bus_addr = baddr_q;
    assign lif.busy     = (state_q == WAIT)
                        || ((state_q == IDLE) && lif.start && ld_type);
    assign lif.rd_valid = (state_q == DONE);
    assign lif.rd_data  = data_q;
    assign lif.exc      = exc_q;
endmodule

// File: tb/tb_load_unit.sv
// Randomized and directed bench for load_unit against a
// cycle-level reference model of the load protocol.
module tb_load_unit;
    localparam int TO = 4;

    logic clk;
    logic reset;
    int   nchk;
    int   nerr;
    logic [31:0] exp_data;
    logic [1:0]  exp_exc;

    load_unit_if lif ();

    load_unit #(
        .TIMEOUT(TO),
        .CNT_W  (3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .lif  (lif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        nchk++;
        assert (obs === expv)
        else begin
            nerr++;
            $error("FAIL %s: got %h want %h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] ext(input logic [2:0] ct,
                                        input logic [1:0] off,
                                        input logic [31:0] d);
        int unsigned b;
        int unsigned h;
        b = (d >> (8 * off)) & 32'hFF;
        h = (d >> (16 * (off / 2))) & 32'hFFFF;
        case (ct)
            3'd1: return d;
            3'd2: return h;
            3'd3: return (h >= 32768) ? h - 32'd65536 : h;
            3'd4: return b;
            3'd5: return (b >= 128) ? b - 32'd256 : b;
            default: return 32'd0;
        endcase
    endfunction

    // ackc/errc: cycle (relative to start) where the pulse is driven
    task automatic run_load(input logic [2:0] ct, input logic [31:0] ad,
                            input logic [31:0] rdat, input int ackc,
                            input int errc, input logic sdone);
        logic vld;
        logic mis;
        logic fnd;
        int   e;
        int   ncyc;
        vld = (ct >= 3'd1) && (ct <= 3'd5);
        mis = ((ct == 3'd1) && (ad[1:0] != 2'd0))
            || (((ct == 3'd2) || (ct == 3'd3)) && ad[0]);
        e = -1;
        if (vld && mis) begin
            e = 0;
            exp_exc  = 2'd1;
            exp_data = 32'd0;
        end else if (vld) begin
            e   = TO;
            fnd = 1'b0;
            exp_exc  = 2'd3;
            exp_data = 32'd0;
            for (int c = 1; c <= TO; c++) begin
                if (!fnd && c == errc) begin
                    fnd = 1'b1;
                    e = c;
                    exp_exc  = 2'd2;
                    exp_data = 32'd0;
                end else if (!fnd && c == ackc) begin
                    fnd = 1'b1;
                    e = c;
                    exp_exc  = 2'd0;
                    exp_data = ext(ct, ad[1:0], rdat);
                end
            end
        end
        @(posedge clk);
        #1;
        lif.start     = 1'b1;
        lif.ctrl      = ct;
        lif.addr      = ad;
        lif.bus_rdata = rdat;
        lif.bus_ack   = (ackc == 0);
        lif.bus_err   = (errc == 0);
        @(negedge clk);
        chk("busy_c0", 32'(lif.busy), 32'(vld));
        chk("req_c0", 32'(lif.bus_req), 32'd0);
        ncyc = vld ? e + 2 : 3;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk);
            #1;
            lif.start   = sdone && vld && (c == e + 1);
            lif.bus_ack = (c == ackc);
            lif.bus_err = (c == errc);
            @(negedge clk);
            chk("bus_req", 32'(lif.bus_req), 32'(c <= e));
            chk("busy", 32'(lif.busy), 32'(c <= e));
            chk("rd_valid", 32'(lif.rd_valid), 32'(c == e + 1));
            if (c <= e)
                chk("bus_addr", lif.bus_addr, {ad[31:2], 2'b00});
            if (!vld || c > e) begin
                chk("rd_data", lif.rd_data, exp_data);
                chk("exc", 32'(lif.exc), 32'(exp_exc));
            end
        end
        lif.start   = 1'b0;
        lif.bus_ack = 1'b0;
        lif.bus_err = 1'b0;
    endtask

    initial begin
        nchk = 0;
        nerr = 0;
        exp_data = 32'd0;
        exp_exc  = 2'd0;
        reset = 1'b0;
        lif.start     = 1'b0;
        lif.addr      = 32'd0;
        lif.ctrl      = 3'd0;
        lif.bus_rdata = 32'd0;
        lif.bus_ack   = 1'b0;
        lif.bus_err   = 1'b0;
        #3;
        chk("rst_req", 32'(lif.bus_req), 32'd0);
        chk("rst_addr", lif.bus_addr, 32'd0);
        chk("rst_valid", 32'(lif.rd_valid), 32'd0);
        chk("rst_data", lif.rd_data, 32'd0);
        chk("rst_exc", 32'(lif.exc), 32'd0);
        chk("rst_busy", 32'(lif.busy), 32'd0);
        #10;
        reset = 1'b1;

        run_load(3'd5, 32'h0000_1003, 32'h80FF_1234, 1, -1, 1'b0);
        run_load(3'd2, 32'h0000_0012, 32'hBEEF_0000, 3, -1, 1'b0);
        run_load(3'd3, 32'h0000_0012, 32'hBEEF_0000, 3, -1, 1'b0);
        run_load(3'd1, 32'h0000_0006, 32'h1234_5678, 1, -1, 1'b0);
        run_load(3'd1, 32'h0000_0040, 32'hCAFE_F00D, 2, 2, 1'b0);
        run_load(3'd1, 32'h0000_0080, 32'h1111_2222, -1, -1, 1'b0);
        run_load(3'd1, 32'h0000_0080, 32'h3333_4444, 4, -1, 1'b1);
        run_load(3'd0, 32'h0000_0100, 32'h5555_6666, 1, -1, 1'b0);
        run_load(3'd7, 32'h0000_0100, 32'h5555_6666, 1, -1, 1'b0);

        @(posedge clk);
        #1;
        lif.start = 1'b1;
        lif.ctrl  = 3'd1;
        lif.addr  = 32'h0000_0200;
        @(posedge clk);
        #1;
        lif.start = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        exp_data = 32'd0;
        exp_exc  = 2'd0;
        chk("mid_req", 32'(lif.bus_req), 32'd0);
        chk("mid_busy", 32'(lif.busy), 32'd0);
        chk("mid_valid", 32'(lif.rd_valid), 32'd0);
        chk("mid_data", lif.rd_data, 32'd0);
        chk("mid_exc", 32'(lif.exc), 32'd0);
        chk("mid_addr", lif.bus_addr, 32'd0);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_valid", 32'(lif.rd_valid), 32'd0);
            chk("post_req", 32'(lif.bus_req), 32'd0);
        end
        run_load(3'd4, 32'h0000_0001, 32'h0000_AB00, 1, -1, 1'b0);

        for (int i = 0; i < 250; i++) begin
            logic [2:0]  rct;
            logic [31:0] rad;
            logic [31:0] rdt;
            int          ra;
            int          re;
            rct = 3'($urandom_range(0, 7));
            rad = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (rct == 3'd1)
                    rad[1:0] = 2'd0;
                if (rct == 3'd2 || rct == 3'd3)
                    rad[0] = 1'b0;
            end
            rdt = $urandom;
            ra  = $urandom_range(0, 6);
            re  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 5) : -1;
            run_load(rct, rad, rdt, ra, re, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
